// File: rtl/fixed_decoder.sv
// Fixed-predictor decoder: rebuilds PCM samples from warm-up words and order-0..4
// residuals through a two-stage pipeline with a fixed latency of two cycles.
module fixed_decoder #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 21
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iEnable,
  input  logic                  iFrameStart,
  input  logic [2:0]            iOrder,
  input  logic [DATA_WIDTH-1:0] iResidual,
  output logic [DATA_WIDTH-1:0] oSample,
  output logic                  oValid,
  output logic                  oOrderErr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_DECODE
  } state_t;

  localparam logic [2:0] MAX_ORDER = 3'd4;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  // Stage 1 registers
  logic                  s1_valid_q;
  logic                  s1_start_q;
  logic [2:0]            s1_order_q;
  logic [DATA_WIDTH-1:0] s1_word_q;

  // Stage 2 registers and their next-state values
  state_t                state_q, state_d;
  logic [2:0]            order_q, order_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  shift_en;
  logic [DATA_WIDTH-1:0] h1_q, h2_q, h3_q, h4_q;

  logic signed [ACC_WIDTH-1:0] e1, e2, e3, e4, pred;
  logic [2:0]                  start_order;
  logic                        start_illegal;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking assignments here would create ordering-dependent races.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      s1_valid_q <= 1'b0;
      s1_start_q <= 1'b0;
      s1_order_q <= '0;
      s1_word_q  <= '0;
    end else begin
      s1_valid_q <= iEnable;
      if (iEnable) begin
        s1_start_q <= iFrameStart;
        s1_order_q <= iOrder;
        s1_word_q  <= iResidual;
      end
    end
  end

  assign e1 = sext(h1_q);
  assign e2 = sext(h2_q);
  assign e3 = sext(h3_q);
  assign e4 = sext(h4_q);

  // Binomial coefficients built from shifts and adds only.
  always_comb begin
    pred = '0;
    case (order_q)
      3'd1:    pred = e1;
      3'd2:    pred = (e1 <<< 1) - e2;
      3'd3:    pred = (e1 <<< 1) + e1 - ((e2 <<< 1) + e2) + e3;
      3'd4:    pred = (e1 <<< 2) - ((e2 <<< 2) + (e2 <<< 1)) + (e3 <<< 2) - e4;
      default: pred = '0;
    endcase
  end

  assign start_illegal = (s1_order_q > MAX_ORDER);
  assign start_order   = start_illegal ? 3'd0 : s1_order_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    state_d  = state_q;
    order_d  = order_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    shift_en = 1'b0;

    if (s1_valid_q) begin
      if (s1_start_q) begin
        // The frame-start word is warm-up word 1, or a plain order-0 sample.
        order_d  = start_order;
        err_d    = err_q | start_illegal;
        cnt_d    = 3'd1;
        sample_d = s1_word_q;
        valid_d  = 1'b1;
        shift_en = 1'b1;
        state_d  = (start_order <= 3'd1) ? ST_DECODE : ST_WARMUP;
      end else begin
        case (state_q)
          ST_WARMUP: begin
            cnt_d    = cnt_q + 3'd1;
            sample_d = s1_word_q;
            valid_d  = 1'b1;
            shift_en = 1'b1;
            if (cnt_d == order_q) state_d = ST_DECODE;
          end
          ST_DECODE: begin
            sample_d = DATA_WIDTH'(sext(s1_word_q) + pred);
            valid_d  = 1'b1;
            shift_en = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the history registers are reset along with the control state so a
  // post-reset frame starts from a known, all-zero predictor.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q  <= ST_IDLE;
      order_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      h1_q     <= '0;
      h2_q     <= '0;
      h3_q     <= '0;
      h4_q     <= '0;
    end else begin
      state_q  <= state_d;
      order_q  <= order_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      if (shift_en) begin
        h4_q <= h3_q;
        h3_q <= h2_q;
        h2_q <= h1_q;
        h1_q <= sample_d;
      end
    end
  end

  assign oSample   = sample_q;
  assign oValid    = valid_q;
  assign oOrderErr = err_q;

endmodule
